async_handshake_sink: RTL and testbench

//   Destination-side responder for the async_handshake crossing, in the clk_dst domain.
//   - Captures each word presented with a 1-cycle valid_dst pulse into a small FIFO.
//   - Returns the 1-cycle ready_dst acknowledge pulse once the word is stored.
//   - Re-presents buffered words on a level valid/ready stream for downstream logic.
//   - Decouples downstream back-pressure from the crossing's request/acknowledge loop.

---
 rtl/async_handshake_sink_pkg.sv | 13 +
 rtl/sync_fifo.sv | 55 +++++
 rtl/async_handshake_sink.sv | 99 +++++++++
 tb/tb_async_handshake_sink.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/async_handshake_sink_pkg.sv
// Shared definitions for the async_handshake crossing: FSM state encodings
// and the default data width, used by both the sink and the source-side driver.
package async_handshake_sink_pkg;

    localparam int DATA_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        HS_IDLE = 2'd0,
        HS_PEND = 2'd1,
        HS_ACK  = 2'd2
    } hs_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with wrap-around counters; out-of-range pushes/pops
// are ignored and the read port holds the last popped word while empty.
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE      = (AW+1)'(1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_cnt;
    logic [AW:0]       rd_cnt;
    logic [DATA_W-1:0] last_q;
    logic              do_wr;
    logic              do_rd;

    assign count = wr_cnt - rd_cnt;
    assign empty = (wr_cnt == rd_cnt);
    assign full  = (count == FULL_CNT);
    assign do_wr = wr_en & ~full;
    assign do_rd = rd_en & ~empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
            last_q <= '0;
        end else begin
            if (do_wr) wr_cnt <= wr_cnt + ONE;
            if (do_rd) begin
                rd_cnt <= rd_cnt + ONE;
                last_q <= mem[rd_cnt[AW-1:0]];
            end
        end
    end

    // Storage needs no reset: an entry is only visible after it is written.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_cnt[AW-1:0]] <= wr_data;
    end

    assign rd_data = empty ? last_q : mem[rd_cnt[AW-1:0]];

endmodule

// File: rtl/async_handshake_sink.sv
// Destination-side responder of the async_handshake crossing: captures pulsed
// words into a FIFO, acks them, and re-presents them as a valid/ready stream.
// Optional stall counter enabled by defining ASYNC_HS_SINK_STATS_EN.
module async_handshake_sink
    import async_handshake_sink_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int DEPTH  = 4
`ifdef ASYNC_HS_SINK_STATS_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        hs_data,
    input  logic                     hs_valid,
    output logic                     hs_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     proto_err
`ifdef ASYNC_HS_SINK_STATS_EN
    , output logic [CNT_W-1:0]       stall_cnt
`endif
);
    hs_state_t state;
    hs_state_t state_nxt;
    logic      wr_en;
    logic      rd_en;
    logic      full;
    logic      empty;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (hs_data),
        .rd_en   (rd_en),
        .rd_data (out_data),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    assign out_valid = ~empty;
    assign rd_en     = out_ready & ~empty;
    assign hs_ready  = (state == HS_ACK);

    // full reflects the registered count, so a same-cycle pop never frees a slot early.
    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        case (state)
            HS_IDLE: begin
                if (hs_valid) begin
                    if (!full) begin
                        wr_en     = 1'b1;
                        state_nxt = HS_ACK;
                    end else begin
                        state_nxt = HS_PEND;
                    end
                end
            end
            HS_PEND: begin
                if (!full) begin
                    wr_en     = 1'b1;
                    state_nxt = HS_ACK;
                end
            end
            HS_ACK:  state_nxt = HS_IDLE;
            default: state_nxt = HS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HS_IDLE;
            proto_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (hs_valid && state != HS_IDLE) proto_err <= 1'b1;
        end
    end

`ifdef ASYNC_HS_SINK_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (state == HS_PEND && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_async_handshake_sink.sv
// Directed bench for async_handshake_sink with a word scoreboard on the output stream.
module tb_async_handshake_sink;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] hs_data;
    logic       hs_valid;
    logic       hs_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] count;
    logic       proto_err;
`ifdef ASYNC_HS_SINK_STATS_EN
    logic [15:0] stall_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] sb_q [$];

    always #5 clk = ~clk;

    async_handshake_sink #(
        .DATA_W (8),
        .DEPTH  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .hs_data   (hs_data),
        .hs_valid  (hs_valid),
        .hs_ready  (hs_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .proto_err (proto_err)
`ifdef ASYNC_HS_SINK_STATS_EN
        , .stall_cnt (stall_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One clock: sample the output stream at the falling edge, then advance.
    task automatic cyc();
        logic [7:0] exp;
        @(negedge clk);
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("pop_unexpected", {24'h0, out_data}, 32'hFFFF_FFFF);
            end else begin
                exp = sb_q.pop_front();
                chk("pop_data", {24'h0, out_data}, {24'h0, exp});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [7:0] d, input bit expect_store);
        if (expect_store) sb_q.push_back(d);
        hs_data  = d;
        hs_valid = 1'b1;
        cyc();
        hs_valid = 1'b0;
    endtask

    initial begin
        bit seen;
        int max_cnt;

        rst = 1'b1; hs_data = '0; hs_valid = 1'b0; out_ready = 1'b0;
        repeat (3) cyc();
        rst = 1'b0;
        cyc();

        // reset state
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_hs_ready", {31'h0, hs_ready}, 32'h0);
        chk("rst_count", {29'h0, count}, 32'h0);
        chk("rst_proto_err", {31'h0, proto_err}, 32'h0);
        chk("rst_out_data", {24'h0, out_data}, 32'h0);

        // single capture
        pulse(8'hA5, 1'b1);
        chk("t2_ack", {31'h0, hs_ready}, 32'h1);
        chk("t2_out_valid", {31'h0, out_valid}, 32'h1);
        chk("t2_out_data", {24'h0, out_data}, 32'hA5);
        chk("t2_count", {29'h0, count}, 32'h1);
        cyc();
        chk("t2_ack_width", {31'h0, hs_ready}, 32'h0);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        chk("t2_drained", {29'h0, count}, 32'h0);
        chk("t2_hold_data", {24'h0, out_data}, 32'hA5);

        // fill to full, fifth word waits in PEND
        for (int i = 1; i <= 4; i++) begin
            pulse(8'(i), 1'b1);
            chk("t3_ack", {31'h0, hs_ready}, 32'h1);
            cyc();
        end
        chk("t3_full_count", {29'h0, count}, 32'h4);
        pulse(8'h05, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (hs_ready) seen = 1'b1;
            cyc();
        end
        chk("t3_no_fifth_ack", {31'h0, seen}, 32'h0);
        chk("t3_still_full", {29'h0, count}, 32'h4);
`ifdef ASYNC_HS_SINK_STATS_EN
        chk("t3_stall_ge10", {31'h0, (stall_cnt >= 16'd10)}, 32'h1);
`endif
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        chk("t3_no_same_cycle_ack", {31'h0, hs_ready}, 32'h0);
        chk("t3_after_pop", {29'h0, count}, 32'h3);
        cyc();
        chk("t3_late_ack", {31'h0, hs_ready}, 32'h1);
        chk("t3_refilled", {29'h0, count}, 32'h4);
        cyc();
        out_ready = 1'b1;
        for (int i = 0; i < 8 && out_valid; i++) cyc();
        out_ready = 1'b0;
        chk("t3_sb_empty", sb_q.size(), 32'h0);

        // pulse during ACK is a protocol error
        chk("t4_err_clear", {31'h0, proto_err}, 32'h0);
        pulse(8'h3C, 1'b1);
        hs_data  = 8'h77;
        hs_valid = 1'b1;
        cyc();
        hs_valid = 1'b0;
        chk("t4_err_set", {31'h0, proto_err}, 32'h1);
        chk("t4_ignored", {29'h0, count}, 32'h1);
        repeat (3) cyc();
        chk("t4_err_sticky", {31'h0, proto_err}, 32'h1);
        chk("t4_head", {24'h0, out_data}, 32'h3C);
        out_ready = 1'b1;
        cyc();

        // streaming with out_ready held high
        max_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            pulse(8'h10 + 8'(i), 1'b1);
            chk("t5_out_data", {24'h0, out_data}, {24'h0, 8'h10 + 8'(i)});
            chk("t5_ack", {31'h0, hs_ready}, 32'h1);
            if (int'(count) > max_cnt) max_cnt = int'(count);
            cyc();
            if (int'(count) > max_cnt) max_cnt = int'(count);
        end
        chk("t5_max_count", max_cnt, 32'h1);
        chk("t5_sb_empty", sb_q.size(), 32'h0);
        out_ready = 1'b0;

        // reset while stalled in PEND
        for (int i = 0; i < 4; i++) begin
            pulse(8'h40 + 8'(i), 1'b0);
            cyc();
        end
        pulse(8'h44, 1'b0);
        repeat (3) cyc();
        chk("t6_pend_full", {29'h0, count}, 32'h4);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("t6_count", {29'h0, count}, 32'h0);
        chk("t6_out_valid", {31'h0, out_valid}, 32'h0);
        chk("t6_proto_err", {31'h0, proto_err}, 32'h0);
`ifdef ASYNC_HS_SINK_STATS_EN
        chk("t6_stall_clr", {16'h0, stall_cnt}, 32'h0);
`endif
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (hs_ready) seen = 1'b1;
            cyc();
        end
        chk("t6_no_ack", {31'h0, seen}, 32'h0);
        chk("t6_still_empty", {29'h0, count}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
